// File: rtl/cache_pkg.sv
// Shared cache geometry for the tag-match datapath and the cache controller.
// Holds the tag, line and word widths, the associativity, the matching
// typedefs and a 4-bit population count helper.
package cache_pkg;

  localparam int TAG_BITS        = 18;
  localparam int LINE_SIZE_BYTES = 64;
  localparam int LINE_BITS       = 8 * LINE_SIZE_BYTES;
  localparam int OFFSET_BITS     = 6;
  localparam int DATA_WIDTH      = 32;
  localparam int WAYS            = 4;
  localparam int WAY_IDX_BITS    = 2;
  // Number of offset bits that select a 32-bit word inside a line.
  localparam int WORD_IDX_BITS   = OFFSET_BITS - 2;

  typedef logic [TAG_BITS-1:0]   tag_t;
  typedef logic [LINE_BITS-1:0]  line_t;
  typedef logic [DATA_WIDTH-1:0] word_t;

  function automatic logic [2:0] popcount4(input logic [WAYS-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < WAYS; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/comparator_and_mux_4x1_way_match.sv
// way_match: hit detection for a single way.
// Ports:
//   way_tag   - tag stored in this way
//   req_tag   - tag of the current lookup
//   way_valid - valid bit of this way
//   match     - stored tag equals request tag and the way is valid
module way_match
  import cache_pkg::*;
(
  input  logic [TAG_BITS-1:0] way_tag,
  input  logic [TAG_BITS-1:0] req_tag,
  input  logic                way_valid,
  output logic                match
);

  // An invalid way must never hit, even if its stale tag happens to match.
  assign match = way_valid && (way_tag == req_tag);

endmodule

// File: rtl/comparator_and_mux_4x1.sv
// comparator_and_mux_4x1: tag compare and way select for the 4-way
// set-associative cache. Lookup is combinational; the result is registered
// and presented one cycle after the i_req edge.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   i_req             - lookup strobe
//   i_tag, i_offset   - request tag and byte offset
//   i_way_tag         - stored tags, way w at [w*TAG_BITS +: TAG_BITS]
//   i_way_valid       - per-way valid bits
//   i_way_line        - stored lines, way w at [w*LINE_BITS +: LINE_BITS]
//   o_valid           - one-cycle result strobe
//   o_hit, o_hit_onehot, o_way, o_multi_hit - hit status of the lookup
//   o_line, o_word    - selected line and addressed word (zero on miss)
module comparator_and_mux_4x1
  import cache_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_req,
  input  logic [TAG_BITS-1:0]       i_tag,
  input  logic [OFFSET_BITS-1:0]    i_offset,
  input  logic [WAYS*TAG_BITS-1:0]  i_way_tag,
  input  logic [WAYS-1:0]           i_way_valid,
  input  logic [WAYS*LINE_BITS-1:0] i_way_line,
  output logic                      o_valid,
  output logic                      o_hit,
  output logic [WAYS-1:0]           o_hit_onehot,
  output logic [WAY_IDX_BITS-1:0]   o_way,
  output logic                      o_multi_hit,
  output logic [LINE_BITS-1:0]      o_line,
  output logic [DATA_WIDTH-1:0]     o_word
);

  logic [WAYS-1:0]          match;
  logic [WAYS-1:0]          sel;
  logic [WAY_IDX_BITS-1:0]  way_idx;
  line_t                    line_sel;
  word_t                    word_sel;
  logic [WORD_IDX_BITS-1:0] word_idx;
  logic                     multi_hit;
  logic                     unused_offset_lsbs;

  genvar w;
  generate
    for (w = 0; w < WAYS; w++) begin : g_way
      way_match u_way_match (
        .way_tag   (i_way_tag[w*TAG_BITS +: TAG_BITS]),
        .req_tag   (i_tag),
        .way_valid (i_way_valid[w]),
        .match     (match[w])
      );
    end
  endgenerate

  // Scan from the top way down so the lowest matching index is the last
  // one written and therefore wins.
  always_comb begin
    sel     = '0;
    way_idx = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (match[i]) begin
        sel     = '0;
        sel[i]  = 1'b1;
        way_idx = i[WAY_IDX_BITS-1:0];
      end
    end
  end

  // One-hot AND-OR mux; an all-zero select yields an all-zero line.
  always_comb begin
    line_sel = '0;
    for (int i = 0; i < WAYS; i++) begin
      line_sel = line_sel | ({LINE_BITS{sel[i]}} & i_way_line[i*LINE_BITS +: LINE_BITS]);
    end
  end

  // Word select drops the two byte-within-word bits (aligned down).
  assign word_idx           = i_offset[OFFSET_BITS-1:2];
  assign word_sel           = line_sel[{word_idx, 5'b00000} +: DATA_WIDTH];
  assign unused_offset_lsbs = ^i_offset[1:0];
  assign multi_hit          = popcount4(match) > 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid      <= 1'b0;
      o_hit        <= 1'b0;
      o_hit_onehot <= '0;
      o_way        <= '0;
      o_multi_hit  <= 1'b0;
      o_line       <= '0;
      o_word       <= '0;
    end else begin
      o_valid <= i_req;
      // Result fields hold between requests.
      if (i_req) begin
        o_hit        <= |match;
        o_hit_onehot <= sel;
        o_way        <= way_idx;
        o_multi_hit  <= multi_hit;
        o_line       <= line_sel;
        o_word       <= word_sel;
      end
    end
  end

endmodule

// File: tb/tb_comparator_and_mux_4x1.sv
module tb_comparator_and_mux_4x1;
  import cache_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      i_req;
  logic [TAG_BITS-1:0]       i_tag;
  logic [OFFSET_BITS-1:0]    i_offset;
  logic [WAYS*TAG_BITS-1:0]  i_way_tag;
  logic [WAYS-1:0]           i_way_valid;
  logic [WAYS*LINE_BITS-1:0] i_way_line;
  logic                      o_valid;
  logic                      o_hit;
  logic [WAYS-1:0]           o_hit_onehot;
  logic [1:0]                o_way;
  logic                      o_multi_hit;
  logic [LINE_BITS-1:0]      o_line;
  logic [31:0]               o_word;

  tag_t  tags  [WAYS];
  line_t lines [WAYS];

  int checks = 0;
  int errors = 0;

  logic        exp_valid, exp_hit, exp_multi;
  logic [3:0]  exp_oh;
  logic [1:0]  exp_way;
  line_t       exp_line;
  logic [31:0] exp_word;

  always #5 clk = ~clk;

  always_comb begin
    i_way_tag  = '0;
    i_way_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      i_way_tag[w*TAG_BITS +: TAG_BITS]    = tags[w];
      i_way_line[w*LINE_BITS +: LINE_BITS] = lines[w];
    end
  end

  comparator_and_mux_4x1 dut (
    .clk          (clk),
    .rst          (rst),
    .i_req        (i_req),
    .i_tag        (i_tag),
    .i_offset     (i_offset),
    .i_way_tag    (i_way_tag),
    .i_way_valid  (i_way_valid),
    .i_way_line   (i_way_line),
    .o_valid      (o_valid),
    .o_hit        (o_hit),
    .o_hit_onehot (o_hit_onehot),
    .o_way        (o_way),
    .o_multi_hit  (o_multi_hit),
    .o_line       (o_line),
    .o_word       (o_word)
  );

  task automatic chk(input string tag, input logic [LINE_BITS-1:0] got,
                     input logic [LINE_BITS-1:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " o_valid"},      LINE_BITS'(o_valid),      LINE_BITS'(exp_valid));
    chk({tag, " o_hit"},        LINE_BITS'(o_hit),        LINE_BITS'(exp_hit));
    chk({tag, " o_hit_onehot"}, LINE_BITS'(o_hit_onehot), LINE_BITS'(exp_oh));
    chk({tag, " o_way"},        LINE_BITS'(o_way),        LINE_BITS'(exp_way));
    chk({tag, " o_multi_hit"},  LINE_BITS'(o_multi_hit),  LINE_BITS'(exp_multi));
    chk({tag, " o_line"},       o_line,                   exp_line);
    chk({tag, " o_word"},       LINE_BITS'(o_word),       LINE_BITS'(exp_word));
  endtask

  task automatic model_reset();
    exp_valid = 0; exp_hit = 0; exp_multi = 0;
    exp_oh = '0; exp_way = '0; exp_line = '0; exp_word = '0;
  endtask

  // Reference: find the first valid way whose tag equals the request tag,
  // count all such ways, and pull the addressed word out byte by byte.
  task automatic model_edge();
    int first, n, base;
    exp_valid = i_req;
    if (i_req) begin
      first = -1;
      n = 0;
      for (int w = 0; w < WAYS; w++) begin
        if (i_way_valid[w] && tags[w] == i_tag) begin
          n++;
          if (first < 0) first = w;
        end
      end
      exp_hit   = (first >= 0);
      exp_multi = (n > 1);
      exp_oh    = exp_hit ? (4'b0001 << first) : 4'b0000;
      exp_way   = exp_hit ? first[1:0] : 2'd0;
      exp_line  = exp_hit ? lines[first] : '0;
      base      = (int'(i_offset) / 4) * 4;
      exp_word  = '0;
      for (int b = 0; b < 4; b++) exp_word[8*b +: 8] = exp_line[8*(base+b) +: 8];
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic fill_random_lines();
    for (int w = 0; w < WAYS; w++)
      for (int k = 0; k < 16; k++) lines[w][32*k +: 32] = $urandom;
  endtask

  initial begin
    rst = 1'b1; i_req = 1'b0; i_tag = '0; i_offset = '0; i_way_valid = '0;
    for (int w = 0; w < WAYS; w++) begin tags[w] = '0; lines[w] = '0; end
    model_reset();
    #3;
    check_all("reset");
    @(negedge clk); rst = 1'b0;

    // Single hit in way 2.
    fill_random_lines();
    for (int k = 0; k < 16; k++) lines[2][32*k +: 32] = 32'hA000_0000 + k;
    tags[0] = 18'h0001; tags[1] = 18'h0002; tags[2] = 18'h1234; tags[3] = 18'h0003;
    i_way_valid = 4'b1111; i_tag = 18'h1234; i_offset = 6'd20; i_req = 1'b1;
    step("single_hit");
    chk("single_hit word const", LINE_BITS'(o_word), LINE_BITS'(32'hA000_0005));
    chk("single_hit onehot const", LINE_BITS'(o_hit_onehot), LINE_BITS'(4'b0100));

    // Reset mid-request: way 2 still matches, all ways valid.
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("reset_mid_req");
    @(negedge clk); rst = 1'b0; i_req = 1'b0;
    step("post_reset_idle0");
    step("post_reset_idle1");

    // Invalid-way mask: way 1 tag equal but not valid.
    tags[0] = 18'h0100; tags[1] = 18'h2222; tags[2] = 18'h0300; tags[3] = 18'h0400;
    i_way_valid = 4'b1101; i_tag = 18'h2222; i_offset = 6'd8; i_req = 1'b1;
    step("invalid_mask");
    chk("invalid_mask hit const", LINE_BITS'(o_hit), LINE_BITS'(1'b0));

    // Multi-hit: ways 1 and 3.
    fill_random_lines();
    tags[0] = 18'h0011; tags[1] = 18'h3ABC; tags[2] = 18'h0022; tags[3] = 18'h3ABC;
    i_way_valid = 4'b1111; i_tag = 18'h3ABC; i_offset = 6'd36;
    step("multi_hit");
    chk("multi_hit way const", LINE_BITS'(o_way), LINE_BITS'(2'd1));
    chk("multi_hit flag const", LINE_BITS'(o_multi_hit), LINE_BITS'(1'b1));

    // Offset boundaries on a way-0 hit.
    for (int k = 0; k < 16; k++) lines[0][32*k +: 32] = 32'hB000_0000 + k;
    tags[0] = 18'h0555; tags[1] = 18'h0001; tags[2] = 18'h0002; tags[3] = 18'h0003;
    i_tag = 18'h0555;
    i_offset = 6'd0;  step("offset0");
    chk("offset0 word const", LINE_BITS'(o_word), LINE_BITS'(32'hB000_0000));
    i_offset = 6'd3;  step("offset3");
    chk("offset3 word const", LINE_BITS'(o_word), LINE_BITS'(32'hB000_0000));
    i_offset = 6'd60; step("offset60");
    chk("offset60 word const", LINE_BITS'(o_word), LINE_BITS'(32'hB000_000F));
    i_offset = 6'd63; step("offset63");
    chk("offset63 word const", LINE_BITS'(o_word), LINE_BITS'(32'hB000_000F));

    // Back-to-back: hit way 3, then miss, then two idle cycles with the
    // inputs changed to prove the miss result holds.
    tags[0] = 18'h0001; tags[1] = 18'h0002; tags[2] = 18'h0003; tags[3] = 18'h0777;
    i_tag = 18'h0777; i_offset = 6'd12; i_req = 1'b1;
    step("b2b_hit");
    chk("b2b_hit valid const", LINE_BITS'(o_valid), LINE_BITS'(1'b1));
    i_tag = 18'h0999;
    step("b2b_miss");
    chk("b2b_miss valid const", LINE_BITS'(o_valid), LINE_BITS'(1'b1));
    chk("b2b_miss hit const", LINE_BITS'(o_hit), LINE_BITS'(1'b0));
    i_req = 1'b0; i_tag = 18'h0001;
    step("idle0");
    chk("idle0 valid const", LINE_BITS'(o_valid), LINE_BITS'(1'b0));
    step("idle1");
    chk("idle1 word const", LINE_BITS'(o_word), LINE_BITS'(32'h0));

    // Randomized traffic drawn from a small tag pool so hits and
    // multi-hits happen often.
    for (int it = 0; it < 300; it++) begin
      if ((it % 8) == 0) fill_random_lines();
      for (int w = 0; w < WAYS; w++) tags[w] = 18'($urandom_range(0, 3));
      i_tag       = 18'($urandom_range(0, 3));
      i_way_valid = 4'($urandom);
      i_offset    = 6'($urandom);
      i_req       = ($urandom_range(0, 3) != 0);
      step("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
